// File: rtl/shot_scheduler.sv
// Laser shot sequencer: parses a 9-byte BD-framed command and fires Tstart
// pulses at a programmed period, either as a counted burst or continuously.
module shot_scheduler #(
   parameter int TRIG_W     = 4,
   parameter int MIN_PERIOD = 16,
   parameter int TIMEOUT    = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_in,
   input  logic        data_in_valid,
   output logic        laser_trig,
   output logic [15:0] shot_idx,
   output logic        busy,
   output logic        done,
   output logic        frame_err,
   output logic        cmd_rej
);
   localparam logic [1:0] P_IDLE = 2'd0;
   localparam logic [1:0] P_BODY = 2'd1;
   localparam logic [1:0] P_CHK  = 2'd2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FIRE = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [7:0]       SYNC_BYTE = 8'hBD;
   localparam int               GAP_W     = $clog2(TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT - 1);
   localparam logic [31:0]      TRIG_LAST = 32'(TRIG_W - 1);
   localparam logic [31:0]      MIN_P     = 32'(MIN_PERIOD);

   // ---------------- frame parser ----------------
   logic [1:0]       p_state_reg;
   logic [2:0]       byte_cnt_reg;
   logic [55:0]      shift_reg;
   logic [7:0]       xor_reg;
   logic [GAP_W-1:0] gap_cnt_reg;
   logic             cmd_stb_reg;
   logic [1:0]       cmd_code_reg;
   logic [31:0]      cfg_period_reg;
   logic [15:0]      cfg_count_reg;
   logic             frame_err_reg;

   logic [7:0]  f_cmd;
   logic [31:0] f_period;
   logic [15:0] f_count;
   logic        cmd_known;
   logic        period_ok;
   logic        frame_ok;

   assign f_cmd     = shift_reg[55:48];
   assign f_period  = shift_reg[47:16];
   assign f_count   = shift_reg[15:0];
   assign cmd_known = (f_cmd == 8'h01) || (f_cmd == 8'h02) || (f_cmd == 8'h03);
   // Stop frames carry period/count only for the checksum, so they skip the period test.
   assign period_ok = (f_cmd == 8'h02) || (f_period >= MIN_P);
   assign frame_ok  = (xor_reg == data_in) && cmd_known && period_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_state_reg    <= P_IDLE;
         byte_cnt_reg   <= 3'd0;
         shift_reg      <= 56'd0;
         xor_reg        <= 8'd0;
         gap_cnt_reg    <= '0;
         cmd_stb_reg    <= 1'b0;
         cmd_code_reg   <= 2'd0;
         cfg_period_reg <= MIN_P;
         cfg_count_reg  <= 16'd0;
         frame_err_reg  <= 1'b0;
      end else begin
         cmd_stb_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
         case (p_state_reg)
            P_IDLE: begin
               if (data_in_valid && (data_in == SYNC_BYTE)) begin
                  p_state_reg  <= P_BODY;
                  byte_cnt_reg <= 3'd0;
                  xor_reg      <= 8'd0;
                  gap_cnt_reg  <= '0;
               end
            end
            P_BODY: begin
               if (data_in_valid) begin
                  shift_reg    <= {shift_reg[47:0], data_in};
                  xor_reg      <= xor_reg ^ data_in;
                  gap_cnt_reg  <= '0;
                  byte_cnt_reg <= byte_cnt_reg + 3'd1;
                  if (byte_cnt_reg == 3'd6) begin
                     p_state_reg <= P_CHK;
                  end
               end
            end
            P_CHK: begin
               if (data_in_valid) begin
                  gap_cnt_reg <= '0;
                  p_state_reg <= P_IDLE;
                  if (frame_ok) begin
                     cmd_stb_reg  <= 1'b1;
                     cmd_code_reg <= f_cmd[1:0];
                     if (f_cmd != 8'h02) begin
                        cfg_period_reg <= f_period;
                        cfg_count_reg  <= f_count;
                     end
                  end else begin
                     frame_err_reg <= 1'b1;
                  end
               end
            end
            default: p_state_reg <= P_IDLE;
         endcase
         // Inter-byte watchdog; overrides the state update above on expiry.
         if ((p_state_reg == P_BODY || p_state_reg == P_CHK) && !data_in_valid) begin
            if (gap_cnt_reg == GAP_LAST) begin
               frame_err_reg <= 1'b1;
               p_state_reg   <= P_IDLE;
               gap_cnt_reg   <= '0;
            end else begin
               gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
         end
      end
   end

   // ---------------- shot scheduler ----------------
   logic [1:0]  s_state_reg,    s_state_next;
   logic [31:0] per_cnt_reg,    per_cnt_next;
   logic [31:0] run_period_reg, run_period_next;
   logic [15:0] run_count_reg,  run_count_next;
   logic        run_cont_reg,   run_cont_next;
   logic        stop_pend_reg,  stop_pend_next;
   logic        trig_reg,       trig_next;
   logic [15:0] shot_idx_reg,   shot_idx_next;
   logic        busy_reg,       busy_next;
   logic        done_reg,       done_next;
   logic        rej_reg,        rej_next;

   logic start_stb;
   logic stop_stb;
   logic period_end;
   logic last_shot;

   assign start_stb  = cmd_stb_reg && (cmd_code_reg != 2'd2);
   assign stop_stb   = cmd_stb_reg && (cmd_code_reg == 2'd2);
   assign period_end = (per_cnt_reg == run_period_reg - 32'd1);
   assign last_shot  = !run_cont_reg && (shot_idx_reg == run_count_reg - 16'd1);

   always_comb begin
      s_state_next    = s_state_reg;
      per_cnt_next    = per_cnt_reg + 32'd1;
      run_period_next = run_period_reg;
      run_count_next  = run_count_reg;
      run_cont_next   = run_cont_reg;
      stop_pend_next  = stop_pend_reg;
      trig_next       = trig_reg;
      shot_idx_next   = shot_idx_reg;
      busy_next       = busy_reg;
      done_next       = 1'b0;
      rej_next        = 1'b0;
      case (s_state_reg)
         S_IDLE, S_DONE: begin
            s_state_next = S_IDLE;
            per_cnt_next = per_cnt_reg;
            if (start_stb) begin
               run_period_next = cfg_period_reg;
               run_count_next  = cfg_count_reg;
               run_cont_next   = (cmd_code_reg == 2'd3);
               if ((cmd_code_reg == 2'd1) && (cfg_count_reg == 16'd0)) begin
                  done_next = 1'b1;
               end else begin
                  s_state_next   = S_FIRE;
                  trig_next      = 1'b1;
                  busy_next      = 1'b1;
                  shot_idx_next  = 16'd0;
                  per_cnt_next   = 32'd0;
                  stop_pend_next = 1'b0;
               end
            end
         end
         S_FIRE: begin
            if (stop_stb) begin
               stop_pend_next = 1'b1;
            end else if (start_stb) begin
               rej_next = 1'b1;
            end
            // A stop seen during the pulse is honoured only once the pulse is complete.
            if (per_cnt_reg == TRIG_LAST) begin
               trig_next = 1'b0;
               if (stop_pend_reg || stop_stb) begin
                  s_state_next = S_DONE;
                  done_next    = 1'b1;
                  busy_next    = 1'b0;
               end else begin
                  s_state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (stop_stb) begin
               s_state_next = S_DONE;
               done_next    = 1'b1;
               busy_next    = 1'b0;
            end else begin
               if (start_stb) begin
                  rej_next = 1'b1;
               end
               if (period_end) begin
                  if (last_shot) begin
                     s_state_next = S_DONE;
                     done_next    = 1'b1;
                     busy_next    = 1'b0;
                  end else begin
                     s_state_next  = S_FIRE;
                     trig_next     = 1'b1;
                     per_cnt_next  = 32'd0;
                     shot_idx_next = shot_idx_reg + 16'd1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_state_reg    <= S_IDLE;
         per_cnt_reg    <= 32'd0;
         run_period_reg <= MIN_P;
         run_count_reg  <= 16'd0;
         run_cont_reg   <= 1'b0;
         stop_pend_reg  <= 1'b0;
         trig_reg       <= 1'b0;
         shot_idx_reg   <= 16'd0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         rej_reg        <= 1'b0;
      end else begin
         s_state_reg    <= s_state_next;
         per_cnt_reg    <= per_cnt_next;
         run_period_reg <= run_period_next;
         run_count_reg  <= run_count_next;
         run_cont_reg   <= run_cont_next;
         stop_pend_reg  <= stop_pend_next;
         trig_reg       <= trig_next;
         shot_idx_reg   <= shot_idx_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         rej_reg        <= rej_next;
      end
   end

   assign laser_trig = trig_reg;
   assign shot_idx   = shot_idx_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign frame_err  = frame_err_reg;
   assign cmd_rej    = rej_reg;

endmodule

// File: tb/tb_shot_scheduler.sv
// Bench for shot_scheduler: directed frames plus randomized bursts, with
// expected pulse times derived from frame timing and the programmed period.
module tb_shot_scheduler;
   localparam int TRIG_W     = 4;
   localparam int MIN_PERIOD = 16;
   localparam int TIMEOUT    = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic        data_in_valid;
   logic        laser_trig;
   logic [15:0] shot_idx;
   logic        busy;
   logic        done;
   logic        frame_err;
   logic        cmd_rej;

   shot_scheduler #(
      .TRIG_W(TRIG_W), .MIN_PERIOD(MIN_PERIOD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .laser_trig(laser_trig), .shot_idx(shot_idx), .busy(busy), .done(done),
      .frame_err(frame_err), .cmd_rej(cmd_rej)
   );

   always #5 clk = ~clk;

   int pcyc = 0;
   always @(posedge clk) pcyc <= pcyc + 1;

   int total = 0;
   int bad   = 0;
   int last_edge = 0;

   int rise_q[$];
   int idx_q[$];
   int fall_q[$];
   int done_q[$];
   int ferr_q[$];
   int rej_q[$];
   int brise_q[$];
   int bfall_q[$];
   logic trig_q = 1'b0;
   logic busy_q = 1'b0;

   // Event log, sampled mid-cycle; times are the count of rising edges seen so far.
   always @(negedge clk) begin
      if (laser_trig && !trig_q) begin
         rise_q.push_back(pcyc);
         idx_q.push_back(int'(shot_idx));
      end
      if (!laser_trig && trig_q) fall_q.push_back(pcyc);
      if (busy && !busy_q) brise_q.push_back(pcyc);
      if (!busy && busy_q) bfall_q.push_back(pcyc);
      if (done) done_q.push_back(pcyc);
      if (frame_err) ferr_q.push_back(pcyc);
      if (cmd_rej) rej_q.push_back(pcyc);
      trig_q <= laser_trig;
      busy_q <= busy;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_in = b;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      data_in = 8'h00;
      last_edge = pcyc;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] period,
                             input logic [15:0] count, input logic [7:0] flip,
                             input int max_gap);
      logic [7:0] fb [9];
      fb[0] = 8'hBD;
      fb[1] = cmd;
      fb[2] = period[31:24];
      fb[3] = period[23:16];
      fb[4] = period[15:8];
      fb[5] = period[7:0];
      fb[6] = count[15:8];
      fb[7] = count[7:0];
      fb[8] = fb[1] ^ fb[2] ^ fb[3] ^ fb[4] ^ fb[5] ^ fb[6] ^ fb[7] ^ flip;
      for (int i = 0; i < 9; i++) begin
         send_byte(fb[i]);
         if (i < 8 && max_gap > 0) idle($urandom_range(max_gap, 0));
      end
   endtask

   task automatic clear_q();
      rise_q.delete(); idx_q.delete(); fall_q.delete(); done_q.delete();
      ferr_q.delete(); rej_q.delete(); brise_q.delete(); bfall_q.delete();
   endtask

   // Burst model: shot k rises at b8+1+k*period, run ends exactly count periods later.
   task automatic verify_burst(input string tag, input int b8, input int period, input int count);
      check({tag, " rises"}, rise_q.size(), count);
      for (int k = 0; k < rise_q.size() && k < count; k++) begin
         check({tag, " rise_t"}, rise_q[k], b8 + 1 + k * period);
         check({tag, " idx"}, idx_q[k], k);
         if (k < fall_q.size()) check({tag, " width"}, fall_q[k] - rise_q[k], TRIG_W);
      end
      check({tag, " dones"}, done_q.size(), 1);
      if (done_q.size() > 0) check({tag, " done_t"}, done_q[0], b8 + 1 + count * period);
      check({tag, " busy_rises"}, brise_q.size(), 1);
      if (brise_q.size() > 0) check({tag, " busy_rise_t"}, brise_q[0], b8 + 1);
      if (bfall_q.size() > 0) check({tag, " busy_fall_t"}, bfall_q[0], b8 + 1 + count * period);
      check({tag, " ferr"}, ferr_q.size(), 0);
   endtask

   initial begin
      int b8a, b8b, p, c, lb;
      rst = 1'b1;
      data_in = 8'h00;
      data_in_valid = 1'b0;
      idle(3);
      check("rst trig", laser_trig, 0);
      check("rst idx", shot_idx, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst ferr", frame_err, 0);
      check("rst rej", cmd_rej, 0);
      rst = 1'b0;
      idle(3);
      clear_q();

      // 1: three-shot burst at period 32
      send_frame(8'h01, 32'h20, 16'd3, 8'h00, 0);
      b8a = last_edge;
      idle(3 * 32 + 10);
      verify_burst("burst3", b8a, 32, 3);
      $display("step burst3 b8=%0d rises=%0d", b8a, rise_q.size());
      clear_q();

      // 2: corrupted checksum
      send_frame(8'h01, 32'h20, 16'd3, 8'h01, 0);
      b8a = last_edge;
      idle(40);
      check("badsum ferr", ferr_q.size(), 1);
      if (ferr_q.size() > 0) check("badsum ferr_t", ferr_q[0], b8a);
      check("badsum rises", rise_q.size(), 0);
      check("badsum busy", brise_q.size(), 0);
      $display("step badsum b8=%0d ferr=%0d", b8a, ferr_q.size());
      clear_q();

      // 3: continuous at period 16, stop mid-wait after shot 5
      send_frame(8'h03, 32'h10, 16'd0, 8'h00, 0);
      b8a = last_edge;
      idle(81);
      send_frame(8'h02, 32'h0, 16'd0, 8'h00, 0);
      b8b = last_edge;
      idle(40);
      check("cont rises", rise_q.size(), 6);
      for (int k = 0; k < rise_q.size() && k < 6; k++) begin
         check("cont rise_t", rise_q[k], b8a + 1 + k * 16);
         check("cont idx", idx_q[k], k);
      end
      check("cont dones", done_q.size(), 1);
      if (done_q.size() > 0) check("cont done_t", done_q[0], b8b + 1);
      if (bfall_q.size() > 0) check("cont busy_fall_t", bfall_q[0], b8b + 1);
      check("cont idx_hold", shot_idx, 5);
      check("cont busy", busy, 0);
      $display("step cont stop_b8=%0d rises=%0d", b8b, rise_q.size());
      clear_q();

      // 4a: period below minimum
      send_frame(8'h01, 32'h08, 16'd2, 8'h00, 0);
      b8a = last_edge;
      idle(30);
      check("minp ferr", ferr_q.size(), 1);
      if (ferr_q.size() > 0) check("minp ferr_t", ferr_q[0], b8a);
      check("minp rises", rise_q.size(), 0);
      $display("step minp ferr=%0d", ferr_q.size());
      clear_q();

      // 4b: frame stalls after B3
      send_byte(8'hBD); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      lb = last_edge;
      idle(TIMEOUT + 10);
      check("tmo ferr", ferr_q.size(), 1);
      if (ferr_q.size() > 0)
         check("tmo window", (ferr_q[0] >= lb + TIMEOUT - 1) && (ferr_q[0] <= lb + TIMEOUT + 1), 1);
      check("tmo rises", rise_q.size(), 0);
      $display("step timeout last=%0d ferr=%0d", lb, ferr_q.size());
      clear_q();
      send_frame(8'h01, 32'd20, 16'd2, 8'h00, 0);
      b8a = last_edge;
      idle(2 * 20 + 10);
      verify_burst("after_tmo", b8a, 20, 2);
      $display("step after_tmo rises=%0d", rise_q.size());
      clear_q();

      // 5: start while busy is rejected
      send_frame(8'h01, 32'd16, 16'd10, 8'h00, 0);
      b8a = last_edge;
      idle(20);
      send_frame(8'h03, 32'd40, 16'd1, 8'h00, 0);
      b8b = last_edge;
      idle(10 * 16 + 20);
      verify_burst("rej_burst", b8a, 16, 10);
      check("rej count", rej_q.size(), 1);
      if (rej_q.size() > 0) check("rej_t", rej_q[0], b8b + 1);
      $display("step rej rises=%0d rej=%0d", rise_q.size(), rej_q.size());
      clear_q();

      // 6: reset during a trig pulse, then garbage before a frame
      send_frame(8'h01, 32'd16, 16'd5, 8'h00, 0);
      idle(18);
      check("prerst trig", laser_trig, 1);
      check("prerst idx", shot_idx, 1);
      rst = 1'b1;
      idle(1);
      check("midrst trig", laser_trig, 0);
      check("midrst busy", busy, 0);
      check("midrst idx", shot_idx, 0);
      rst = 1'b0;
      idle(4);
      clear_q();
      send_byte(8'h00);
      send_byte(8'h55);
      send_frame(8'h01, 32'd16, 16'd1, 8'h00, 0);
      b8a = last_edge;
      idle(30);
      verify_burst("garbage", b8a, 16, 1);
      $display("step reset_garbage rises=%0d", rise_q.size());
      clear_q();

      // Randomized bursts with random byte gaps and a leading junk byte
      for (int it = 0; it < 5; it++) begin
         logic [7:0] junk;
         p = $urandom_range(48, MIN_PERIOD);
         c = $urandom_range(4, 1);
         junk = 8'($urandom_range(255, 0));
         if (junk == 8'hBD) junk = 8'h00;
         send_byte(junk);
         send_frame(8'h01, 32'(p), 16'(c), 8'h00, 3);
         b8a = last_edge;
         idle(c * p + 8);
         verify_burst("rand", b8a, p, c);
         $display("step rand period=%0d count=%0d rises=%0d", p, c, rise_q.size());
         clear_q();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
